// File: rtl/ad_sample_avalon.sv
// ad_sample_avalon
//   Turns each rising edge of the ad_clk sample strobe into one 16-bit frame read
//   from an external serial ADC. The sample (the low DATA_W bits of the frame) goes
//   into a FIFO that the Nios reads over an Avalon-MM slave. A level interrupt is
//   raised when the FIFO fill level reaches a programmable threshold.
//
// Ports
//   clk, rst_n          single clock domain, synchronous active-low reset
//   ad_clk              asynchronous sample strobe; a rising edge starts one conversion
//   address[1:0]        Avalon word address
//   read, write         Avalon strobes
//   writedata[31:0]     Avalon write data
//   readdata[31:0]      Avalon read data (combinational, zero wait states)
//   irq                 level interrupt: enable && count >= threshold && threshold != 0
//   adc_cs_n            ADC chip select, active-low
//   adc_sclk            ADC serial clock, idles low
//   adc_dout            ADC serial data, MSB first
//
// Bus handshake: there is no waitrequest. A read or write strobe high at a clk edge
// is one complete transfer. readdata is valid in the same cycle the read strobe is
// high, and a read of register 0 pops the FIFO on the edge that ends that cycle.
//
// Register map
//   0 R  : FIFO head, zero-extended; the read pops it. Empty FIFO reads 0, no pop.
//   1 R  : [4:0] count, [8] busy, [9] overflow, [10] missed, [11] irq
//   1 W  : write-1-to-clear for bits 9 and 10
//   2 RW : [0] enable, [7:4] irq threshold, [1] clear (write-only, self-clearing)
//   3 R  : samples pushed (wrapping 32-bit counter); 3 W: any write zeroes it

module ad_sample_avalon #(
  parameter int DATA_W     = 12,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ad_clk,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  input  logic        adc_dout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int CMP_W = (CNT_W > 4) ? CNT_W : 4;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] STOP_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SHIFT = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Strobe synchroniser and rise detect
  // ---------------------------------------------------------------------------
  logic [1:0] ad_sync;
  logic       ad_prev;
  logic       rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ad_sync <= 2'b00;
      ad_prev <= 1'b0;
    end else begin
      ad_sync <= {ad_sync[0], ad_clk};
      ad_prev <= ad_sync[1];
    end
  end

  assign rise = ad_sync[1] & ~ad_prev;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr_stat;
  logic wr_ctrl;
  logic wr_scnt;
  logic rd_data;
  logic ctrl_clear;

  assign wr_stat    = write && (address == 2'd1);
  assign wr_ctrl    = write && (address == 2'd2);
  assign wr_scnt    = write && (address == 2'd3);
  assign rd_data    = read  && (address == 2'd0);
  assign ctrl_clear = wr_ctrl && writedata[1];

  // ---------------------------------------------------------------------------
  // Control register
  // ---------------------------------------------------------------------------
  logic       enable;
  logic [3:0] threshold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable    <= 1'b0;
      threshold <= 4'd0;
    end else if (wr_ctrl) begin
      enable    <= writedata[0];
      threshold <= writedata[7:4];
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [3:0]       bit_cnt, bit_nxt;
  logic             phase, phase_nxt;   // 0 = SCLK low half, 1 = SCLK high half
  logic             shift_en;
  logic             frame_done;
  logic             cs_n_c;
  logic             sclk_c;
  logic [15:0]      shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= 4'd0;
      phase   <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      phase   <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    bit_nxt    = bit_cnt;
    phase_nxt  = phase;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    cs_n_c     = 1'b1;
    sclk_c     = 1'b0;

    case (state)
      S_IDLE: begin
        if (rise && enable) begin
          state_nxt = S_START;
          div_nxt   = '0;
        end
      end

      S_START: begin
        cs_n_c = 1'b0;
        if (div_cnt == DIV_LAST) begin
          state_nxt = S_SHIFT;
          div_nxt   = '0;
          bit_nxt   = 4'd0;
          phase_nxt = 1'b0;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      S_SHIFT: begin
        cs_n_c = 1'b0;
        sclk_c = phase;
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (!phase) begin
            // SCLK goes high on this edge: take the bit the ADC is presenting.
            phase_nxt = 1'b1;
            shift_en  = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            if (bit_cnt == 4'd15) begin
              state_nxt  = S_STOP;
              frame_done = 1'b1;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (div_cnt == STOP_LAST) begin
          state_nxt = S_IDLE;
          div_nxt   = '0;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        div_nxt   = '0;
      end
    endcase

    // A control clear aborts whatever frame is running and suppresses its push.
    if (ctrl_clear) begin
      state_nxt  = S_IDLE;
      div_nxt    = '0;
      bit_nxt    = 4'd0;
      phase_nxt  = 1'b0;
      shift_en   = 1'b0;
      frame_done = 1'b0;
    end
  end

  assign adc_cs_n = cs_n_c;
  assign adc_sclk = sclk_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= 16'd0;
    end else if (shift_en) begin
      shreg <= {shreg[14:0], adc_dout};
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;
  logic              overflow_set;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_FULL);
  assign pop        = rd_data && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok      = frame_done && (!fifo_full || pop);
  assign overflow_set = frame_done && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= shreg[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || ctrl_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags and sample counter
  // ---------------------------------------------------------------------------
  logic        overflow;
  logic        missed;
  logic        missed_set;
  logic        busy;
  logic [31:0] sample_cnt;

  assign busy       = (state != S_IDLE);
  assign missed_set = rise && busy;

  // Set beats a same-cycle write-1-to-clear; control clear beats both.
  always_ff @(posedge clk) begin
    if (!rst_n || ctrl_clear) begin
      overflow <= 1'b0;
      missed   <= 1'b0;
    end else begin
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (wr_stat && writedata[9]) begin
        overflow <= 1'b0;
      end
      if (missed_set) begin
        missed <= 1'b1;
      end else if (wr_stat && writedata[10]) begin
        missed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || wr_scnt) begin
      sample_cnt <= 32'd0;
    end else if (push_ok) begin
      sample_cnt <= sample_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt and read mux
  // ---------------------------------------------------------------------------
  assign irq = enable && (threshold != 4'd0) &&
               (CMP_W'(fifo_count) >= CMP_W'(threshold));

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: begin
        if (!fifo_empty) begin
          readdata = 32'(mem[rd_ptr]);
        end
      end
      2'd1: begin
        readdata[4:0] = 5'(fifo_count);
        readdata[8]   = busy;
        readdata[9]   = overflow;
        readdata[10]  = missed;
        readdata[11]  = irq;
      end
      2'd2: begin
        readdata[0]   = enable;
        readdata[7:4] = threshold;
      end
      default: begin
        readdata = sample_cnt;
      end
    endcase
  end

  // Writedata bits with no register behind them, and frame bits above DATA_W.
  logic unused_bits;
  assign unused_bits = ^{writedata[31:11], writedata[8], writedata[3:2], shreg};

endmodule

// File: tb/tb_ad_sample_avalon.sv
module tb_ad_sample_avalon;

  localparam int DATA_W     = 12;
  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ad_clk = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_dout = 1'b0;

  always #5 clk = ~clk;

  ad_sample_avalon #(
    .DATA_W    (DATA_W),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ad_clk   (ad_clk),
    .address  (address),
    .read     (read),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata),
    .irq      (irq),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .adc_dout (adc_dout)
  );

  // ---------------------------------------------------------------------------
  // ADC model: presents MSB on CS fall, next bit on each SCLK fall
  // ---------------------------------------------------------------------------
  logic [15:0] adc_word = 16'd0;
  int          bit_idx = 0;
  int          sclk_pulses = 0;

  always @(negedge adc_cs_n) begin
    bit_idx  = 15;
    adc_dout = adc_word[15];
  end

  always @(negedge adc_sclk) begin
    if (!adc_cs_n && bit_idx > 0) begin
      bit_idx  = bit_idx - 1;
      adc_dout = adc_word[bit_idx];
    end
  end

  always @(posedge adc_sclk) sclk_pulses = sclk_pulses + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int                vec_cnt = 0;
  int                err_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int cnt, input bit busy, input bit ovf,
                                        input bit msd, input bit irq_b);
    logic [31:0] v;
    v       = 32'd0;
    v[4:0]  = 5'(cnt);
    v[8]    = busy;
    v[9]    = ovf;
    v[10]   = msd;
    v[11]   = irq_b;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
    writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    #1 d = readdata;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic reg_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    bus_read(2'd0, d);
    exp = 32'd0;
    if (exp_q.size() > 0) exp = 32'(exp_q.pop_front());
    check(tag, d, exp);
  endtask

  task automatic strobe();
    @(negedge clk);
    ad_clk = 1'b1;
    repeat (3) @(negedge clk);
    ad_clk = 1'b0;
  endtask

  task automatic convert(input logic [15:0] w);
    adc_word = w;
    strobe();
    repeat (80) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] d;
    logic [15:0] w;
    int          cs_low;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reg_check("rst_reg0", 2'd0, 32'd0);
    reg_check("rst_reg1", 2'd1, 32'd0);
    reg_check("rst_reg2", 2'd2, 32'd0);
    reg_check("rst_reg3", 2'd3, 32'd0);

    // 1: single conversion, frame timing
    bus_write(2'd2, 32'h1);
    reg_check("t1_reg2", 2'd2, 32'h1);
    adc_word    = 16'h5ABC;
    sclk_pulses = 0;
    cs_low      = 0;
    @(negedge clk);
    ad_clk = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (c == 3) ad_clk = 1'b0;
      if (c == 2) check("t1_idle_c2", 32'(adc_cs_n), 32'd1);
      if (c == 3) check("t1_start_c3", 32'(adc_cs_n), 32'd0);
      if (!adc_cs_n) cs_low++;
    end
    check("t1_sclk_pulses", 32'(sclk_pulses), 32'd16);
    check("t1_cs_low", 32'(cs_low), 32'd66);
    exp_q.push_back(12'hABC);
    reg_check("t1_reg1", 2'd1, stat(1, 0, 0, 0, 0));
    pop_check("t1_pop");
    reg_check("t1_reg1_after", 2'd1, 32'd0);
    reg_check("t1_reg3", 2'd3, 32'd1);

    // 2: 17 conversions into a 16-deep FIFO
    bus_write(2'd3, 32'h0);
    for (int i = 0; i < 17; i++) begin
      w = 16'(i * 599) ^ 16'hA5A0;
      if (i < 16) exp_q.push_back(w[DATA_W-1:0]);
      convert(w);
    end
    reg_check("t2_reg1", 2'd1, stat(16, 0, 1, 0, 0));
    reg_check("t2_reg3", 2'd3, 32'd16);
    for (int i = 0; i < 17; i++) pop_check("t2_pop");
    reg_check("t2_reg1_empty", 2'd1, stat(0, 0, 1, 0, 0));
    bus_write(2'd1, 32'h200);
    reg_check("t2_w1c_ovf", 2'd1, 32'd0);

    // 3: strobe during a frame
    bus_write(2'd3, 32'h0);
    adc_word = 16'h0123;
    strobe();
    repeat (20) @(negedge clk);
    strobe();
    repeat (80) @(negedge clk);
    exp_q.push_back(12'h123);
    reg_check("t3_reg1", 2'd1, stat(1, 0, 0, 1, 0));
    reg_check("t3_reg3", 2'd3, 32'd1);
    pop_check("t3_pop");
    bus_write(2'd1, 32'h400);
    reg_check("t3_w1c_missed", 2'd1, 32'd0);

    // 4: threshold interrupt
    bus_write(2'd2, 32'h41);
    reg_check("t4_reg2", 2'd2, 32'h41);
    for (int i = 1; i <= 3; i++) begin
      w = 16'(i * 16'h0111);
      exp_q.push_back(w[DATA_W-1:0]);
      convert(w);
    end
    check("t4_irq_cnt3", 32'(irq), 32'd0);
    reg_check("t4_reg1_cnt3", 2'd1, stat(3, 0, 0, 0, 0));
    exp_q.push_back(12'h444);
    convert(16'h0444);
    check("t4_irq_cnt4", 32'(irq), 32'd1);
    reg_check("t4_reg1_cnt4", 2'd1, stat(4, 0, 0, 0, 1));
    pop_check("t4_pop");
    check("t4_irq_after_pop", 32'(irq), 32'd0);
    exp_q.push_back(12'h555);
    convert(16'h0555);
    check("t4_irq_again", 32'(irq), 32'd1);
    bus_write(2'd2, 32'h40);
    check("t4_irq_disabled", 32'(irq), 32'd0);
    reg_check("t4_reg1_disabled", 2'd1, stat(4, 0, 0, 0, 0));
    bus_write(2'd2, 32'h43);
    exp_q.delete();
    reg_check("t4_reg2_clear_rd0", 2'd2, 32'h41);
    reg_check("t4_reg1_flushed", 2'd1, 32'd0);

    // 5: control clear mid-shift, then reset mid-frame
    bus_write(2'd2, 32'h1);
    bus_write(2'd3, 32'h0);
    adc_word = 16'hFFFF;
    strobe();
    repeat (27) @(negedge clk);
    check("t5_cs_active", 32'(adc_cs_n), 32'd0);
    reg_check("t5_busy", 2'd1, stat(0, 1, 0, 0, 0));
    bus_write(2'd2, 32'h3);
    check("t5_cs_released", 32'(adc_cs_n), 32'd1);
    check("t5_sclk_low", 32'(adc_sclk), 32'd0);
    reg_check("t5_idle", 2'd1, 32'd0);
    repeat (80) @(negedge clk);
    reg_check("t5_no_push", 2'd1, 32'd0);
    reg_check("t5_reg3", 2'd3, 32'd0);

    convert(16'h0456);
    bus_write(2'd2, 32'h11);
    check("t5_irq_pre_rst", 32'(irq), 32'd1);
    adc_word = 16'h0789;
    strobe();
    repeat (20) @(negedge clk);
    strobe();
    repeat (5) @(negedge clk);
    reg_check("t5_pre_rst_reg1", 2'd1, stat(1, 1, 0, 1, 1));
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("t5_rst_sclk", 32'(adc_sclk), 32'd0);
    check("t5_rst_irq", 32'(irq), 32'd0);
    reg_check("t5_rst_reg1", 2'd1, 32'd0);
    reg_check("t5_rst_reg2", 2'd2, 32'd0);
    reg_check("t5_rst_reg3", 2'd3, 32'd0);
    reg_check("t5_rst_reg0", 2'd0, 32'd0);
    rst_n = 1'b1;
    exp_q.delete();

    // 6: pop on the same edge as a push into a full FIFO
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 16; i++) begin
      w = 16'hC000 | 16'(i * 16'h0101);
      exp_q.push_back(w[DATA_W-1:0]);
      convert(w);
    end
    reg_check("t6_full", 2'd1, stat(16, 0, 0, 0, 0));
    adc_word = 16'h3DEF;
    @(negedge clk);
    ad_clk = 1'b1;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      if (c == 3) ad_clk = 1'b0;
    end
    check("t6_cs_before_push", 32'(adc_cs_n), 32'd0);
    address = 2'd0;
    read    = 1'b1;
    #1 d = readdata;
    check("t6_pop_head", d, 32'(exp_q.pop_front()));
    exp_q.push_back(12'hDEF);
    @(negedge clk);
    read = 1'b0;
    check("t6_cs_after_push", 32'(adc_cs_n), 32'd1);
    repeat (20) @(negedge clk);
    reg_check("t6_reg1", 2'd1, stat(16, 0, 0, 0, 0));
    reg_check("t6_reg3", 2'd3, 32'd17);
    for (int i = 0; i < 16; i++) pop_check("t6_order");
    reg_check("t6_empty", 2'd1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
